// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise logic unit: one of 8 bitwise ops per beat, optional burst fold of B operands,
// single registered output stage with zero/all-ones/parity flags and a saturating beat count.

module bitwise_logic_lane (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    case (op)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = a ^ b;
      3'd3:    y = ~(a & b);
      3'd4:    y = ~(a | b);
      3'd5:    y = ~(a ^ b);
      3'd6:    y = a & ~b;
      default: y = a;
    endcase
  end
endmodule

module bitwise_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             accept, finish_beat, in_idle;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] opnd_a, res;
  logic [CNT_W-1:0] cnt_next;

  assign in_idle  = (state == S_IDLE);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == S_ACCUM);

  // Inside a burst the running accumulator stands in for A, so PASS_A keeps the first-beat A.
  assign op_sel = in_idle ? in_op : op_q;
  assign opnd_a = in_idle ? in_a  : acc;

  // mode=1 with last=1 in IDLE is a one-beat burst, i.e. a single
  assign finish_beat = in_idle ? (!in_mode || in_last) : in_last;
  assign cnt_next    = in_idle ? CNT_W'(1)
                     : ((cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1));

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    bitwise_logic_lane u_lane (
      .op (op_sel),
      .a  (opnd_a[i]),
      .b  (in_b[i]),
      .y  (res[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_zero   <= 1'b0;
      out_ones   <= 1'b0;
      out_parity <= 1'b0;
      out_count  <= '0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (finish_beat) begin
          out_valid  <= 1'b1;
          out_data   <= res;
          out_zero   <= (res == '0);
          out_ones   <= &res;
          out_parity <= ^res;
          out_count  <= cnt_next;
          state      <= S_IDLE;
        end else begin
          acc   <= res;
          cnt   <= cnt_next;
          state <= S_ACCUM;
          if (in_idle) op_q <= in_op;
        end
      end
    end
  end
endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit: directed scenarios plus randomized singles/bursts,
// expected results folded from whole-burst operand lists.
module tb_bitwise_logic_unit;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic [2:0]    in_op = '0;
  logic          in_mode = 1'b0, in_last = 1'b0;
  logic          out_valid, out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_zero, out_ones, out_parity, busy;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  bitwise_logic_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity),
    .out_count(out_count), .busy(busy)
  );

  typedef struct packed { logic [W-1:0] d; logic [CW-1:0] c; } exp_t;
  exp_t sbq[$];

  int checks = 0, failures = 0;
  int ready_ctl = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  // Reference model: remembers a whole burst and folds it when the last beat arrives.
  bit           in_burst = 0;
  logic [2:0]   bop;
  logic [W-1:0] ba;
  logic [W-1:0] bq[$];

  always begin
    @(negedge clk); #4;
    if (!rst_n) begin
      in_burst = 0; bq.delete(); sbq.delete();
    end else if (in_valid && in_ready) begin
      if (!in_burst) begin
        if (!in_mode || in_last) sbq.push_back('{d: f(in_op, in_a, in_b), c: CW'(1)});
        else begin
          in_burst = 1; bop = in_op; ba = in_a; bq.delete(); bq.push_back(in_b);
        end
      end else begin
        bq.push_back(in_b);
        if (in_last) begin
          logic [W-1:0] r;
          int n;
          r = ba;
          foreach (bq[i]) r = f(bop, r, bq[i]);
          n = bq.size();
          sbq.push_back('{d: r, c: CW'((n > 15) ? 15 : n)});
          in_burst = 0;
        end
      end
    end
  end

  // Monitor: pops on every output handshake, also watches hold-under-backpressure and busy.
  bit           prev_hold = 0;
  logic [W-1:0] prev_data;
  logic [CW-1:0] prev_cnt;

  always begin
    @(negedge clk); #3;
    if (!rst_n) prev_hold = 0;
    else begin
      chk("busy", busy, in_burst);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_count", out_count, prev_cnt);
      end
      if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out act=%0h req=none", out_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("data", out_data, e.d);
          chk("count", out_count, e.c);
          chk("zero", out_zero, e.d == '0);
          chk("ones", out_ones, &e.d);
          chk("parity", out_parity, ^e.d);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_cnt  = out_count;
    end
  end

  always @(negedge clk)
    out_ready = (ready_ctl == 0) ? 1'b1 : (ready_ctl == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic mode, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_mode = mode; in_last = last;
    #2;
    n = 0;
    while (!in_ready) begin
      @(negedge clk); #2;
      n++;
      if (n > 1000) begin
        checks++; failures++;
        $display("FAIL accept_timeout act=stalled req=accept");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); in_valid = 1'b0; end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_ones", out_ones, 0);
    chk("rst_parity", out_parity, 0);
    chk("rst_count", out_count, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;

    // single AND, then all ops on A5/0F
    beat(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
    for (int op = 0; op < 8; op++) beat(8'hA5, 8'h0F, 3'(op), 1'b0, 1'b0);
    idle(2);

    // OR burst; later beats carry junk A/op/mode that must be ignored
    beat(8'h01, 8'h01, 3'd1, 1'b1, 1'b0);
    beat(W'($urandom), 8'h02, 3'($urandom), 1'b0, 1'b0);
    beat(W'($urandom), 8'h04, 3'($urandom), 1'b1, 1'b0);
    beat(W'($urandom), 8'h08, 3'($urandom), 1'b0, 1'b1);
    idle(2);

    // backpressure then release
    ready_ctl = 2;
    beat(8'h3C, 8'h55, 3'd2, 1'b0, 1'b0);
    idle(3);
    #2 chk("t4_in_ready", in_ready, 0);
    fork
      begin repeat (4) @(posedge clk); ready_ctl = 0; end
      beat(8'h12, 8'h34, 3'd1, 1'b0, 1'b0);
    join
    idle(2);

    // saturating AND burst of 20 beats
    for (int i = 0; i < 20; i++) beat(8'hFF, 8'hFF, 3'd0, 1'b1, 1'(i == 19));
    idle(3);

    // reset mid-burst
    for (int i = 0; i < 3; i++) beat(8'h77, W'($urandom), 3'd2, 1'b1, 1'b0);
    idle(1);
    @(negedge clk); rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    beat(8'hFF, 8'hFF, 3'd2, 1'b0, 1'b0);
    idle(2);

    // randomized singles and bursts under random backpressure
    ready_ctl = 1;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 0)
        beat(W'($urandom), W'($urandom), 3'($urandom), 1'b0, 1'($urandom));
      else begin
        int nb;
        nb = $urandom_range(1, 20);
        for (int i = 0; i < nb; i++) begin
          beat(W'($urandom), W'($urandom), 3'($urandom), 1'b1, 1'(i == nb - 1));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    ready_ctl = 0;

    for (int n = 0; n < 200 && (sbq.size() != 0 || out_valid); n++) @(negedge clk);
    #4;
    chk("drain_pending", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
